// File: rtl/dynamixel_status_receiver.sv
// Dynamixel 2.0 status-packet receiver: 8N1 UART RX, header/length parser, on-the-fly unstuffing and CRC-16.
// Optional inter-byte timeout is enabled by defining DYNAMIXEL_RX_TIMEOUT_EN.
module dynamixel_status_receiver #(
  parameter int unsigned clocks_per_bit = 1,
  parameter int unsigned timeout_clocks = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pin,
  output logic        valid,
  output logic        crc_error,
  output logic        busy,
  output logic [7:0]  id,
  output logic [7:0]  error,
  output logic [15:0] param_count,
  output logic [31:0] value
);

  localparam int unsigned cnt_w    = $clog2(clocks_per_bit + 1);
  localparam int unsigned half_bit = clocks_per_bit / 2;
`ifdef DYNAMIXEL_RX_TIMEOUT_EN
  localparam bit timeout_en = 1'b1;
`else
  localparam bit timeout_en = 1'b0;
`endif

  typedef enum logic [1:0] {rx_idle, rx_start, rx_data, rx_stop} rx_state_t;
  typedef enum logic [3:0] {
    p_h1, p_h2, p_h3, p_rsv, p_id, p_len_l, p_len_h,
    p_instr, p_err, p_param, p_crc_l, p_crc_h
  } p_state_t;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {b, 8'h00};
    for (int i = 0; i < 8; i++) r = r[15] ? ((r << 1) ^ 16'h8005) : (r << 1);
    return r;
  endfunction

  rx_state_t        rx_state;
  logic             sync0, sync1, rx_prev;
  logic [cnt_w-1:0] clk_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic [7:0]       rx_byte;
  logic             byte_ready, frame_err;

  // UART receiver; clk_cnt counts cycles since the last sample point
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync0      <= 1'b1;
      sync1      <= 1'b1;
      rx_prev    <= 1'b1;
      rx_state   <= rx_idle;
      clk_cnt    <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      rx_byte    <= '0;
      byte_ready <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      sync0      <= pin;
      sync1      <= sync0;
      rx_prev    <= sync1;
      byte_ready <= 1'b0;
      frame_err  <= 1'b0;
      case (rx_state)
        rx_idle: begin
          if (rx_prev && !sync1) begin
            clk_cnt  <= cnt_w'(1);
            bit_idx  <= '0;
            rx_state <= (half_bit == 0) ? rx_data : rx_start;
          end
        end
        rx_start: begin
          if (clk_cnt == cnt_w'(half_bit)) begin
            clk_cnt  <= cnt_w'(1);
            rx_state <= sync1 ? rx_idle : rx_data;
          end else begin
            clk_cnt <= clk_cnt + cnt_w'(1);
          end
        end
        rx_data: begin
          if (clk_cnt == cnt_w'(clocks_per_bit)) begin
            clk_cnt <= cnt_w'(1);
            shift   <= {sync1, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) rx_state <= rx_stop;
          end else begin
            clk_cnt <= clk_cnt + cnt_w'(1);
          end
        end
        rx_stop: begin
          if (clk_cnt == cnt_w'(clocks_per_bit)) begin
            rx_state <= rx_idle;
            if (sync1) begin
              byte_ready <= 1'b1;
              rx_byte    <= shift;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + cnt_w'(1);
          end
        end
        default: rx_state <= rx_idle;
      endcase
    end
  end

  p_state_t    p_state;
  logic [15:0] crc, len, rem, pidx;
  logic [7:0]  id_q, err_q, crc_lo;
  logic [23:0] hist;
  logic [31:0] val_q;
  logic [31:0] idle_cnt;
  logic [15:0] crc_upd, crc_hdr, len_full;
  logic        stuffed, timeout_hit;

  assign crc_upd  = crc_step(crc, rx_byte);
  assign crc_hdr  = crc_step(crc_step(16'h0000, 8'hFF), 8'hFF);
  assign len_full = {rx_byte, len[7:0]};
  assign stuffed  = (hist == 24'hFFFFFD) && (rx_byte == 8'hFD);

  // Inter-byte watchdog, only live when the timeout feature is built in
  always_ff @(posedge clock or posedge reset) begin
    if (reset) idle_cnt <= '0;
    else if (byte_ready || !busy) idle_cnt <= '0;
    else idle_cnt <= idle_cnt + 32'd1;
  end

  assign timeout_hit = timeout_en && busy && !byte_ready &&
                       (idle_cnt == 32'(timeout_clocks - 1));

  // Packet parser; advances once per received byte
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      p_state     <= p_h1;
      valid       <= 1'b0;
      crc_error   <= 1'b0;
      busy        <= 1'b0;
      id          <= '0;
      error       <= '0;
      param_count <= '0;
      value       <= '0;
      crc         <= '0;
      len         <= '0;
      rem         <= '0;
      pidx        <= '0;
      id_q        <= '0;
      err_q       <= '0;
      crc_lo      <= '0;
      hist        <= '0;
      val_q       <= '0;
    end else begin
      valid     <= 1'b0;
      crc_error <= 1'b0;
      if (frame_err || timeout_hit) begin
        p_state <= p_h1;
        busy    <= 1'b0;
        crc     <= '0;
      end else if (byte_ready) begin
        rem <= rem - 16'd1;
        case (p_state)
          p_h1: begin
            if (rx_byte == 8'hFF) begin
              p_state <= p_h2;
              busy    <= 1'b1;
              crc     <= crc_upd;
            end
          end
          p_h2: begin
            if (rx_byte == 8'hFF) begin
              p_state <= p_h3;
              crc     <= crc_upd;
            end else begin
              p_state <= p_h1;
              busy    <= 1'b0;
              crc     <= '0;
            end
          end
          p_h3: begin
            if (rx_byte == 8'hFD) begin
              p_state <= p_rsv;
              crc     <= crc_upd;
            end else if (rx_byte == 8'hFF) begin
              crc <= crc_hdr;  // extra leading 0xFF: keep only the last two in the CRC
            end else begin
              p_state <= p_h1;
              busy    <= 1'b0;
              crc     <= '0;
            end
          end
          p_rsv: begin
            if (rx_byte == 8'h00) begin
              p_state <= p_id;
              crc     <= crc_upd;
            end else begin
              p_state <= p_h1;
              busy    <= 1'b0;
              crc     <= '0;
            end
          end
          p_id: begin
            id_q    <= rx_byte;
            crc     <= crc_upd;
            p_state <= p_len_l;
          end
          p_len_l: begin
            len[7:0] <= rx_byte;
            crc      <= crc_upd;
            p_state  <= p_len_h;
          end
          p_len_h: begin
            len[15:8] <= rx_byte;
            rem       <= len_full;
            if (len_full < 16'd4 || len_full > 16'h0FFF) begin
              p_state <= p_h1;
              busy    <= 1'b0;
              crc     <= '0;
            end else begin
              crc     <= crc_upd;
              p_state <= p_instr;
            end
          end
          p_instr: begin
            if (rx_byte == 8'h55) begin
              crc     <= crc_upd;
              p_state <= p_err;
            end else begin
              p_state <= p_h1;
              busy    <= 1'b0;
              crc     <= '0;
            end
          end
          p_err: begin
            err_q   <= rx_byte;
            crc     <= crc_upd;
            hist    <= {16'h0000, rx_byte};
            pidx    <= '0;
            val_q   <= '0;
            p_state <= (len == 16'd4) ? p_crc_l : p_param;
          end
          p_param: begin
            crc <= crc_upd;
            if (stuffed) begin
              hist <= '0;
            end else begin
              hist <= {hist[15:0], rx_byte};
              pidx <= pidx + 16'd1;
              if (pidx < 16'd4) val_q[{pidx[1:0], 3'b000} +: 8] <= rx_byte;
            end
            if (rem == 16'd3) p_state <= p_crc_l;
          end
          p_crc_l: begin
            crc_lo  <= rx_byte;
            p_state <= p_crc_h;
          end
          p_crc_h: begin
            p_state <= p_h1;
            busy    <= 1'b0;
            crc     <= '0;
            if ({rx_byte, crc_lo} == crc) begin
              valid       <= 1'b1;
              id          <= id_q;
              error       <= err_q;
              param_count <= pidx;
              value       <= val_q;
            end else begin
              crc_error <= 1'b1;
            end
          end
          default: begin
            p_state <= p_h1;
            busy    <= 1'b0;
            crc     <= '0;
          end
        endcase
      end
    end
  end

endmodule
